// File: rtl/stu_multi_pe_arbiter.sv
// ---------------------------------------------------------------------------
// stu_multi_pe_arbiter
//
// Merges NUM_CH PE upstream ports into a single stack-bus upstream port.
// Every channel owns a small FIFO. A round-robin arbiter grants one channel
// at a time and keeps the grant from SOM through EOM, so messages from
// different channels never interleave. Each output word is tagged with the
// channel it came from. A sticky flag records cntl framing errors.
//
// Ports
//   clk                     clock, all state on posedge
//   reset_poweron_n         asynchronous active-low reset
//   pe__stu__valid   [N]    per-channel word valid
//   pe__stu__cntl    [2N]   per-channel cntl: 01 SOM, 00 MOM, 10 EOM, 11 SOM_EOM
//   pe__stu__type    [N*T]  per-channel type
//   pe__stu__data    [N*D]  per-channel data
//   pe__stu__oob_data[N*O]  per-channel out-of-band data
//   stu__pe__ready   [N]    per-channel ready (FIFO not full)
//   stu__sys__valid         merged word valid
//   stu__sys__cntl          merged cntl
//   stu__sys__type          merged type
//   stu__sys__data          merged data
//   stu__sys__oob_data      merged out-of-band data
//   stu__sys__ch_id         source channel of the current word
//   sys__stu__ready         downstream ready
//   stu__sys__protocol_err  sticky framing-error flag
// ---------------------------------------------------------------------------
module stu_multi_pe_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 64,
  parameter int OOB_W      = 32,
  parameter int TYPE_W     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       reset_poweron_n,
  input  logic [NUM_CH-1:0]          pe__stu__valid,
  input  logic [NUM_CH*2-1:0]        pe__stu__cntl,
  input  logic [NUM_CH*TYPE_W-1:0]   pe__stu__type,
  input  logic [NUM_CH*DATA_W-1:0]   pe__stu__data,
  input  logic [NUM_CH*OOB_W-1:0]    pe__stu__oob_data,
  output logic [NUM_CH-1:0]          stu__pe__ready,
  output logic                       stu__sys__valid,
  output logic [1:0]                 stu__sys__cntl,
  output logic [TYPE_W-1:0]          stu__sys__type,
  output logic [DATA_W-1:0]          stu__sys__data,
  output logic [OOB_W-1:0]           stu__sys__oob_data,
  output logic [CH_W-1:0]            stu__sys__ch_id,
  input  logic                       sys__stu__ready,
  output logic                       stu__sys__protocol_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  typedef struct packed {
    logic [1:0]        cntl;
    logic [TYPE_W-1:0] typ;
    logic [DATA_W-1:0] data;
    logic [OOB_W-1:0]  oob;
  } word_t;

  state_e          state_q, state_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic [CH_W-1:0] rr_last_q, rr_last_d;
  logic            first_q, first_d;   // next output word is the first of the message
  logic            err_q, err_d;

  logic [NUM_CH-1:0] empty;
  word_t             heads [NUM_CH];
  word_t             head;
  logic              out_valid;
  logic              xfer;

  // -------------------------------------------------------------------------
  // Per-channel FIFOs
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    word_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push, pop;
    word_t            in_word;

    assign in_word = '{cntl: pe__stu__cntl[g*2 +: 2],
                       typ:  pe__stu__type[g*TYPE_W +: TYPE_W],
                       data: pe__stu__data[g*DATA_W +: DATA_W],
                       oob:  pe__stu__oob_data[g*OOB_W +: OOB_W]};

    // Ready comes from the registered count only: a full FIFO stays not-ready
    // even while it is being popped, and it is forced low while in reset.
    assign stu__pe__ready[g] = reset_poweron_n && (count_q < DEPTH_C);
    assign empty[g]          = (count_q == '0);
    assign push              = pe__stu__valid[g] && stu__pe__ready[g];
    assign pop               = xfer && (grant_q == CH_W'(g));
    assign heads[g]          = mem_q[rd_ptr_q];

    // NOTE: the storage array has no reset; only pointers and count need one,
    // since an empty FIFO never exposes its contents as valid.
    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_word;
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
      if (!reset_poweron_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        // Simultaneous push and pop leaves the count unchanged.
        if (push && !pop)      count_q <= count_q + CNT_W'(1);
        else if (pop && !push) count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output datapath: head of the granted FIFO, zeroed when not valid
  // -------------------------------------------------------------------------
  assign head      = heads[grant_q];
  assign out_valid = (state_q == ST_BUSY) && !empty[grant_q];
  assign xfer      = out_valid && sys__stu__ready;

  assign stu__sys__valid        = out_valid;
  assign stu__sys__cntl         = out_valid ? head.cntl : '0;
  assign stu__sys__type         = out_valid ? head.typ  : '0;
  assign stu__sys__data         = out_valid ? head.data : '0;
  assign stu__sys__oob_data     = out_valid ? head.oob  : '0;
  assign stu__sys__ch_id        = out_valid ? grant_q   : '0;
  assign stu__sys__protocol_err = err_q;

  // -------------------------------------------------------------------------
  // Round-robin pick: first non-empty channel after rr_last
  // -------------------------------------------------------------------------
  logic            found;
  logic [CH_W-1:0] pick;
  logic [CH_W-1:0] idx;

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(rr_last_q) + k) % NUM_CH);
      if (!found && !empty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Arbiter FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    first_d   = first_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = pick;
          first_d = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (xfer) begin
          first_d = 1'b0;
          // cntl[0] is the SOM bit: the first word must carry it and every
          // later word must not. The word is forwarded either way.
          if (first_q != head.cntl[0]) err_d = 1'b1;
          // cntl[1] is the EOM bit: only it ends the message.
          if (head.cntl[1]) begin
            rr_last_d = grant_q;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_last_q <= CH_W'(NUM_CH - 1);  // channel 0 wins the first arbitration
      first_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      first_q   <= first_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_stu_multi_pe_arbiter.sv
module tb_stu_multi_pe_arbiter;

  localparam int NUM_CH     = 4;
  localparam int DATA_W     = 64;
  localparam int OOB_W      = 32;
  localparam int TYPE_W     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int CH_W       = 2;

  typedef struct packed {
    logic [1:0]        cntl;
    logic [TYPE_W-1:0] typ;
    logic [DATA_W-1:0] data;
    logic [OOB_W-1:0]  oob;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Per-channel stimulus, packed onto the DUT buses below
  logic              pv [NUM_CH];
  logic [1:0]        pc [NUM_CH];
  logic [TYPE_W-1:0] pt [NUM_CH];
  logic [DATA_W-1:0] pd [NUM_CH];
  logic [OOB_W-1:0]  po [NUM_CH];

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*2-1:0]      in_cntl;
  logic [NUM_CH*TYPE_W-1:0] in_type;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH*OOB_W-1:0]  in_oob;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      in_valid[i]                      = pv[i];
      in_cntl[i*2 +: 2]                = pc[i];
      in_type[i*TYPE_W +: TYPE_W]      = pt[i];
      in_data[i*DATA_W +: DATA_W]      = pd[i];
      in_oob[i*OOB_W +: OOB_W]         = po[i];
    end
  end

  logic [NUM_CH-1:0] pe_ready;
  logic              sys_valid;
  logic [1:0]        sys_cntl;
  logic [TYPE_W-1:0] sys_type;
  logic [DATA_W-1:0] sys_data;
  logic [OOB_W-1:0]  sys_oob;
  logic [CH_W-1:0]   sys_ch;
  logic              sys_ready;
  logic              proto_err;

  stu_multi_pe_arbiter dut (
    .clk                    (clk),
    .reset_poweron_n        (rst_n),
    .pe__stu__valid         (in_valid),
    .pe__stu__cntl          (in_cntl),
    .pe__stu__type          (in_type),
    .pe__stu__data          (in_data),
    .pe__stu__oob_data      (in_oob),
    .stu__pe__ready         (pe_ready),
    .stu__sys__valid        (sys_valid),
    .stu__sys__cntl         (sys_cntl),
    .stu__sys__type         (sys_type),
    .stu__sys__data         (sys_data),
    .stu__sys__oob_data     (sys_oob),
    .stu__sys__ch_id        (sys_ch),
    .sys__stu__ready        (sys_ready),
    .stu__sys__protocol_err (proto_err)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int acc_cnt [NUM_CH];
  bit done3, done6;

  // Scoreboard: one expected queue per channel, plus a log of every transfer
  word_t exp_q [NUM_CH][$];
  int    log_ch  [$];
  int    log_cyc [$];
  logic  log_err [$];   // protocol_err as seen just before this transfer

  bit               hold_v;
  word_t            held_w;
  logic [CH_W-1:0]  held_ch;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: sampled on the falling edge, mid-cycle
  always @(negedge clk) begin
    word_t got;
    word_t exp_w;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      got = '{cntl: sys_cntl, typ: sys_type, data: sys_data, oob: sys_oob};
      if (hold_v) begin
        vectors++;
        if (sys_valid !== 1'b1 || got !== held_w || sys_ch !== held_ch) begin
          miscompares++;
          $display("FAIL stall_hold: got valid=%0b ch=%0d data=%h, required valid=1 ch=%0d data=%h",
                   sys_valid, sys_ch, sys_data, held_ch, held_w.data);
        end
      end
      if (sys_valid === 1'b1 && sys_ready) begin
        log_ch.push_back(int'(sys_ch));
        log_cyc.push_back(cyc);
        log_err.push_back(proto_err);
        vectors++;
        if (exp_q[sys_ch].size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: ch=%0d data=%h, required no output", sys_ch, sys_data);
        end else begin
          exp_w = exp_q[sys_ch].pop_front();
          if (got !== exp_w) begin
            miscompares++;
            $display("FAIL out_word ch%0d: got cntl=%b type=%0d data=%h oob=%h, required cntl=%b type=%0d data=%h oob=%h",
                     sys_ch, got.cntl, got.typ, got.data, got.oob,
                     exp_w.cntl, exp_w.typ, exp_w.data, exp_w.oob);
          end
        end
      end
      hold_v  = (sys_valid === 1'b1) && !sys_ready;
      held_w  = got;
      held_ch = sys_ch;
    end
  end

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NUM_CH; i++) s += exp_q[i].size();
    return s;
  endfunction

  function automatic logic [OOB_W-1:0] oob_of(input int ch, input logic [DATA_W-1:0] d);
    return {16'hC0DE, d[15:0]} ^ OOB_W'(ch);
  endfunction

  // Offer one word on a channel and wait until it is accepted
  task automatic send_word(input int ch, input logic [1:0] c, input logic [DATA_W-1:0] d);
    bit ok     = 1'b0;
    int budget = 300;
    pv[ch] = 1'b1;
    pc[ch] = c;
    pt[ch] = d[TYPE_W-1:0];
    pd[ch] = d;
    po[ch] = oob_of(ch, d);
    while (!ok && budget > 0) begin
      @(negedge clk);
      if (pe_ready[ch]) begin
        ok = 1'b1;
        exp_q[ch].push_back('{cntl: c, typ: d[TYPE_W-1:0], data: d, oob: oob_of(ch, d)});
        acc_cnt[ch]++;
      end
      @(posedge clk);
      #1;
      budget--;
    end
    pv[ch] = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout ch%0d: word %h not accepted, required acceptance", ch, d);
    end
  endtask

  task automatic send_msg(input int ch, input int n, input logic [DATA_W-1:0] base);
    logic [1:0] c;
    for (int i = 0; i < n; i++) begin
      if (n == 1)          c = 2'b11;
      else if (i == 0)     c = 2'b01;
      else if (i == n - 1) c = 2'b10;
      else                 c = 2'b00;
      send_word(ch, c, base + DATA_W'(i));
    end
  endtask

  task automatic wait_drain();
    int budget = 500;
    while (budget > 0 && (pending() != 0 || sys_valid)) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d words pending, required 0", pending());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < NUM_CH; i++) exp_q[i].delete();
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string name, input int s, input int exp_ch []);
    vectors++;
    if (log_ch.size() - s != exp_ch.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d transfers, required %0d", name, log_ch.size() - s, exp_ch.size());
    end else begin
      for (int i = 0; i < exp_ch.size(); i++) begin
        vectors++;
        if (log_ch[s+i] != exp_ch[i]) begin
          miscompares++;
          $display("FAIL %s_order[%0d]: got ch%0d, required ch%0d", name, i, log_ch[s+i], exp_ch[i]);
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (sys_valid !== 1'b0 || pe_ready !== 4'h0 || proto_err !== 1'b0 ||
        sys_data !== '0 || sys_ch !== '0 || sys_cntl !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b ready=%b err=%b data=%h ch=%0d cntl=%b, required all 0",
               sys_valid, pe_ready, proto_err, sys_data, sys_ch, sys_cntl);
    end
    #21;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (pe_ready !== 4'hF || sys_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b valid=%b, required ready=1111 valid=0", pe_ready, sys_valid);
    end
  endtask

  task automatic test_single();
    send_word(2, 2'b11, 64'hA5);
    vectors++;
    if (sys_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latency1: valid=%b after 1 edge, required 0", sys_valid);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (sys_valid !== 1'b1 || sys_data !== 64'hA5 || sys_type !== 2'd1 ||
        sys_ch !== 2'd2 || sys_cntl !== 2'b11) begin
      miscompares++;
      $display("FAIL single_out: valid=%b data=%h type=%0d ch=%0d cntl=%b, required 1 a5 1 2 11",
               sys_valid, sys_data, sys_type, sys_ch, sys_cntl);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (sys_valid !== 1'b0 || proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL single_after: valid=%b err=%b, required 0 0", sys_valid, proto_err);
    end
  endtask

  task automatic test_round_robin();
    int s;
    pulse_reset();
    s = log_ch.size();
    fork
      send_msg(0, 3, 64'h200);
      send_msg(1, 3, 64'h210);
      send_msg(2, 3, 64'h220);
      send_msg(3, 3, 64'h230);
    join
    wait_drain();
    check_seq("rr", s, '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3});
    if (log_ch.size() - s == 12) begin
      vectors++;
      if (log_cyc[s+11] - log_cyc[s] != 14) begin
        miscompares++;
        $display("FAIL rr_span: got %0d cycles first-to-last, required 14", log_cyc[s+11] - log_cyc[s]);
      end
    end
  endtask

  task automatic test_backpressure();
    int s, a0, budget;
    s  = log_ch.size();
    a0 = acc_cnt[1];
    sys_ready = 1'b0;
    done3 = 1'b0;
    fork
      begin
        send_msg(1, 6, 64'h300);
        done3 = 1'b1;
      end
    join_none
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (acc_cnt[1] - a0 != FIFO_DEPTH) begin
      miscompares++;
      $display("FAIL bp_accepted: got %0d words, required %0d", acc_cnt[1] - a0, FIFO_DEPTH);
    end
    vectors++;
    if (pe_ready[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_ready: got %b, required 0", pe_ready[1]);
    end
    vectors++;
    if (sys_valid !== 1'b1 || sys_ch !== 2'd1 || sys_data !== 64'h300) begin
      miscompares++;
      $display("FAIL bp_head: valid=%b ch=%0d data=%h, required 1 1 300", sys_valid, sys_ch, sys_data);
    end
    sys_ready = 1'b1;
    budget = 200;
    while (!done3 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    wait_drain();
    check_seq("bp", s, '{1, 1, 1, 1, 1, 1});
  endtask

  task automatic test_framing();
    int s;
    s = log_ch.size();
    vectors++;
    if (proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_pre: err=%b, required 0", proto_err);
    end
    send_word(0, 2'b01, 64'h400);
    send_word(0, 2'b01, 64'h401);
    send_word(0, 2'b10, 64'h402);
    wait_drain();
    check_seq("frame", s, '{0, 0, 0});
    if (log_ch.size() - s == 3) begin
      vectors++;
      if (log_err[s+1] !== 1'b0 || log_err[s+2] !== 1'b1) begin
        miscompares++;
        $display("FAIL frame_when: err before xfer2=%b before xfer3=%b, required 0 1",
                 log_err[s+1], log_err[s+2]);
      end
    end
    vectors++;
    if (proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_sticky: err=%b, required 1", proto_err);
    end
    s = log_ch.size();
    send_msg(2, 1, 64'h4F0);
    wait_drain();
    check_seq("frame_idle", s, '{2});
  endtask

  task automatic test_reset_mid();
    int s;
    bit seen;
    send_word(3, 2'b01, 64'h500);
    send_word(3, 2'b00, 64'h501);
    send_word(3, 2'b00, 64'h502);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (sys_valid !== 1'b0 || pe_ready !== 4'h0 || proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset: valid=%b ready=%b err=%b, required 0 0000 0", sys_valid, pe_ready, proto_err);
    end
    for (int i = 0; i < NUM_CH; i++) exp_q[i].delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (sys_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen || pe_ready !== 4'hF) begin
      miscompares++;
      $display("FAIL midreset_empty: output seen=%b ready=%b, required 0 1111", seen, pe_ready);
    end
    s = log_ch.size();
    fork
      send_msg(3, 1, 64'h5A3);
      send_msg(0, 1, 64'h5A0);
    join
    wait_drain();
    check_seq("midreset_rr", s, '{0, 3});
  endtask

  task automatic test_back_to_back();
    int s, budget;
    s = log_ch.size();
    done6 = 1'b0;
    fork
      begin
        for (int m = 0; m < 4; m++) send_msg(3, 2, 64'h600 + DATA_W'(m * 16));
        done6 = 1'b1;
      end
    join_none
    budget = 50;
    while (log_ch.size() <= s && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    send_msg(0, 2, 64'h6A0);
    budget = 300;
    while (!done6 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    wait_drain();
    check_seq("b2b", s, '{3, 3, 0, 0, 3, 3, 3, 3, 3, 3});
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      pv[i] = 1'b0; pc[i] = '0; pt[i] = '0; pd[i] = '0; po[i] = '0;
      acc_cnt[i] = 0;
    end
    sys_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_framing();
    test_reset_mid();
    test_back_to_back();
    vectors++;
    if (pending() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d expected words never emerged, required 0", pending());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
